// File: rtl/bus_capture_fifo_pkg.sv
// Shared bus constants for the capture FIFO slice.
package bus_capture_fifo_pkg;
  localparam int BUS_WIDTH     = 16;
  localparam int CAPTURE_DEPTH = 4;
endpackage

// File: rtl/bus_capture_fifo.sv
// First-word-fall-through capture FIFO for a shared bus, with sticky
// overflow/underflow flags. Storage is not reset; q is only meaningful while non-empty.
module bus_capture_fifo
  import bus_capture_fifo_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH,
  parameter int DEPTH = CAPTURE_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         DATA,
  input  logic                     load,
  input  logic                     pop,
  input  logic                     clear_err,
  output logic [WIDTH-1:0]         q,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_load, do_pop, ovf_evt, unf_evt;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign q     = mem[rd_ptr];

  // A pop on a full FIFO frees the slot the simultaneous load needs.
  assign do_pop  = pop && !empty;
  assign do_load = load && (!full || pop);
  assign ovf_evt = load && full && !pop;
  assign unf_evt = pop && empty;

  always_ff @(posedge clk) begin
    if (do_load && !reset) mem[wr_ptr] <= DATA;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_load) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_load && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_load) count <= count - CW'(1);
      // New events win over a same-cycle clear.
      overflow  <= ovf_evt || (overflow  && !clear_err);
      underflow <= unf_evt || (underflow && !clear_err);
    end
  end
endmodule

// File: tb/tb_bus_capture_fifo.sv
// Directed self-checking bench for bus_capture_fifo.
module tb_bus_capture_fifo;
  logic        clk = 1'b0;
  logic        reset, load, pop, clear_err;
  logic [15:0] DATA, q;
  logic        empty, full, overflow, underflow;
  logic [2:0]  count;
  int checks = 0;
  int errors = 0;

  bus_capture_fifo dut (
    .clk(clk), .reset(reset), .DATA(DATA), .load(load), .pop(pop),
    .clear_err(clear_err), .q(q), .empty(empty), .full(full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    load = 1'b0; pop = 1'b0; clear_err = 1'b0; reset = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] d);
    DATA = d; load = 1'b1; step();
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; pop = 1'b0; clear_err = 1'b0; DATA = '0;
    step();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if ({empty, full} !== 2'b10) begin errors++; $display("FAIL reset_empty_full got %b want 10", {empty, full}); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {overflow, underflow}); end
  endtask

  task automatic test_single_load();
    do_load(16'h0008);
    checks++; if (q !== 16'h0008) begin errors++; $display("FAIL single_q got %h want 0008", q); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got %0d want 1", count); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty got %b want 0", empty); end
    pop = 1'b1; step();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_drain got %b want 1", empty); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 4; i++) do_load(16'(i));
    checks++; if ({full, count} !== {1'b1, 3'd4}) begin errors++; $display("FAIL fill_full_count got %b/%0d want 1/4", full, count); end
    do_load(16'hFFFF);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
    checks++; if ({full, count} !== {1'b1, 3'd4}) begin errors++; $display("FAIL ovf_count got %b/%0d want 1/4", full, count); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (q !== 16'(i)) begin errors++; $display("FAIL ovf_pop%0d got %h want %h", i, q, 16'(i)); end
      pop = 1'b1; step();
    end
    checks++; if ({empty, full, count} !== {2'b10, 3'd0}) begin errors++; $display("FAIL ovf_drain got %b%b/%0d want 10/0", empty, full, count); end
    clear_err = 1'b1; step();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", overflow); end
  endtask

  task automatic test_full_load_pop();
    for (int i = 1; i <= 4; i++) do_load(16'(i));
    DATA = 16'h0005; load = 1'b1; pop = 1'b1; step();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL flp_count got %0d want 4", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL flp_ovf got %b want 0", overflow); end
    for (int i = 2; i <= 5; i++) begin
      checks++; if (q !== 16'(i)) begin errors++; $display("FAIL flp_pop%0d got %h want %h", i, q, 16'(i)); end
      pop = 1'b1; step();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flp_empty got %b want 1", empty); end
  endtask

  task automatic test_underflow();
    pop = 1'b1; step();
    checks++; if ({underflow, count} !== {1'b1, 3'd0}) begin errors++; $display("FAIL unf_set got %b/%0d want 1/0", underflow, count); end
    clear_err = 1'b1; step();
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL unf_clear got %b want 0", underflow); end
    clear_err = 1'b1; pop = 1'b1; step();
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_priority got %b want 1", underflow); end
    clear_err = 1'b1; step();
    DATA = 16'h0077; load = 1'b1; pop = 1'b1; step();
    checks++; if ({underflow, count} !== {1'b1, 3'd1}) begin errors++; $display("FAIL empty_lp got %b/%0d want 1/1", underflow, count); end
    checks++; if (q !== 16'h0077) begin errors++; $display("FAIL empty_lp_q got %h want 0077", q); end
    pop = 1'b1; clear_err = 1'b1; step();
  endtask

  task automatic test_wrap();
    do_load(16'hA000);
    for (int n = 1; n <= 6; n++) begin
      DATA = 16'hA000 + 16'(n); load = 1'b1; pop = 1'b1;
      checks++; if (q !== 16'hA000 + 16'(n - 1)) begin errors++; $display("FAIL wrap%0d got %h want %h", n, q, 16'hA000 + 16'(n - 1)); end
      step();
    end
    checks++; if ({q, count} !== {16'hA006, 3'd1}) begin errors++; $display("FAIL wrap_end got %h/%0d want a006/1", q, count); end
    pop = 1'b1; step();
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) do_load(16'h0B00 + 16'(i));
    pop = 1'b1; step();
    do_load(16'h0B03);
    do_load(16'hBAD0);
    checks++; if (overflow !== 1'b0 || count !== 3'd4) begin errors++; $display("FAIL pre_reset got %b/%0d want 0/4", overflow, count); end
    do_load(16'hBAD1);
    reset = 1'b1; load = 1'b1; DATA = 16'h1234; step();
    checks++; if ({count, empty, full} !== {3'd0, 2'b10}) begin errors++; $display("FAIL rst_mid got %0d/%b%b want 0/10", count, empty, full); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL rst_mid_flags got %b want 00", {overflow, underflow}); end
    do_load(16'h00AA);
    checks++; if ({q, count} !== {16'h00AA, 3'd1}) begin errors++; $display("FAIL rst_first_load got %h/%0d want 00aa/1", q, count); end
    do_load(16'h00BB);
    pop = 1'b1; step();
    checks++; if (q !== 16'h00BB) begin errors++; $display("FAIL rst_second got %h want 00bb", q); end
    pop = 1'b1; step();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_no_1234 got empty=%b q=%h want 1", empty, q); end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_overflow();
    test_full_load_pop();
    test_underflow();
    test_wrap();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
